// File: rtl/issue_buffer_pkg.sv
// -----------------------------------------------------------------------------
// issue_buffer_pkg
// Shared types for the fetch-to-decode issue buffer.
//   u1/u32/u64     : basic scalar typedefs
//   fetch_entry_t  : one stored instruction {pc, raw}
//   issue_slot_t   : one presented issue slot {valid, pc, raw}
//   clampPop()     : turns the 2-bit pop request into 0, 1 or 2
// -----------------------------------------------------------------------------
package issue_buffer_pkg;

    typedef logic        u1;
    typedef logic [31:0] u32;
    typedef logic [63:0] u64;

    typedef struct packed {
        u64 pc;
        u32 raw;
    } fetch_entry_t;

    typedef struct packed {
        u1  valid;
        u64 pc;
        u32 raw;
    } issue_slot_t;

    // Decode can retire at most two slots; an encoding of 3 means "both".
    function automatic logic [1:0] clampPop(input logic [1:0] popReq);
        return (popReq == 2'd3) ? 2'd2 : popReq;
    endfunction

endpackage

// File: rtl/issue_buffer_ram.sv
// -----------------------------------------------------------------------------
// issue_buffer_ram
// DEPTH x fetch_entry_t storage with two write ports and two asynchronous
// read ports. No reset: contents are only meaningful where the owner's
// pointers say so.
//   clk                      : clock, rising edge
//   we0_i/waddr0_i/wdata0_i  : write port 0
//   we1_i/waddr1_i/wdata1_i  : write port 1 (never the same address as port 0)
//   raddr0_i/rdata0_o        : asynchronous read port 0
//   raddr1_i/rdata1_o        : asynchronous read port 1
// -----------------------------------------------------------------------------
module issue_buffer_ram
    import issue_buffer_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               we0_i,
    input  logic [PTR_W-1:0]   waddr0_i,
    input  fetch_entry_t       wdata0_i,
    input  logic               we1_i,
    input  logic [PTR_W-1:0]   waddr1_i,
    input  fetch_entry_t       wdata1_i,
    input  logic [PTR_W-1:0]   raddr0_i,
    input  logic [PTR_W-1:0]   raddr1_i,
    output fetch_entry_t       rdata0_o,
    output fetch_entry_t       rdata1_o
);

    fetch_entry_t mem_q [DEPTH];

    // Both write ports may fire in one cycle; the owner guarantees distinct
    // addresses, so the order of the two statements is irrelevant.
    always_ff @(posedge clk) begin
        if (we0_i) begin
            mem_q[waddr0_i] <= wdata0_i;
        end
        if (we1_i) begin
            mem_q[waddr1_i] <= wdata1_i;
        end
    end

    assign rdata0_o = mem_q[raddr0_i];
    assign rdata1_o = mem_q[raddr1_i];

endmodule

// File: rtl/issue_buffer.sv
// -----------------------------------------------------------------------------
// issue_buffer
// Dual-issue instruction queue between fetch and decode. Accepts up to two
// instructions per cycle, presents the two oldest as issue slots 0 and 1,
// and retires 0..2 of them per cycle as decode allows. Flush empties it.
//   clk, reset          : clock (rising) and asynchronous active-low reset
//   flush               : redirect, discard everything next cycle
//   in_valid0/1, in_pc0/1, in_raw0/1 : fetch slots (slot 1 needs slot 0)
//   in_ready            : at least two free entries
//   out_valid0/1, out_pc0/1, out_raw0/1 : oldest / second-oldest entries
//   pop                 : slots consumed this cycle (3 means 2)
//   count               : current occupancy 0..DEPTH
// -----------------------------------------------------------------------------
module issue_buffer
    import issue_buffer_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid0,
    input  logic             in_valid1,
    input  logic [63:0]      in_pc0,
    input  logic [63:0]      in_pc1,
    input  logic [31:0]      in_raw0,
    input  logic [31:0]      in_raw1,
    output logic             in_ready,
    output logic             out_valid0,
    output logic             out_valid1,
    output logic [63:0]      out_pc0,
    output logic [63:0]      out_pc1,
    output logic [31:0]      out_raw0,
    output logic [31:0]      out_raw1,
    input  logic [1:0]       pop,
    output logic [PTR_W:0]   count
);

    localparam logic [PTR_W:0] READY_MAX = (PTR_W+1)'(DEPTH - 2);

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;

    logic [1:0]       npush;
    logic [1:0]       npop;
    logic [1:0]       popReq;
    logic             we0;
    logic             we1;
    fetch_entry_t     wdata0;
    fetch_entry_t     wdata1;
    fetch_entry_t     rdata0;
    fetch_entry_t     rdata1;
    issue_slot_t      slot0;
    issue_slot_t      slot1;

    // Only the registered count decides readiness, so pop never reaches
    // in_ready combinationally and a push always has two free slots.
    assign in_ready = (count_q <= READY_MAX);

    assign wdata0 = '{pc: in_pc0, raw: in_raw0};
    assign wdata1 = '{pc: in_pc1, raw: in_raw1};

    // Push/pop amounts and next pointers. Flush overrides everything and
    // also suppresses the RAM writes of a push that arrives with it.
    always_comb begin
        npush   = 2'd0;
        popReq  = clampPop(pop);
        npop    = popReq;
        we0     = 1'b0;
        we1     = 1'b0;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;

        if (in_ready && in_valid0) begin
            npush = in_valid1 ? 2'd2 : 2'd1;
        end

        // Over-pop is trimmed to what is actually stored.
        if ((PTR_W+1)'(popReq) > count_q) begin
            npop = count_q[1:0];
        end

        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            we0     = (npush != 2'd0);
            we1     = (npush == 2'd2);
            head_d  = head_q + PTR_W'(npop);
            tail_d  = tail_q + PTR_W'(npush);
            count_d = count_q + (PTR_W+1)'(npush) - (PTR_W+1)'(npop);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    issue_buffer_ram #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_ram (
        .clk      (clk),
        .we0_i    (we0),
        .waddr0_i (tail_q),
        .wdata0_i (wdata0),
        .we1_i    (we1),
        .waddr1_i (tail_q + PTR_W'(1)),
        .wdata1_i (wdata1),
        .raddr0_i (head_q),
        .raddr1_i (head_q + PTR_W'(1)),
        .rdata0_o (rdata0),
        .rdata1_o (rdata1)
    );

    // Issue slots: data is zeroed whenever the slot is not valid so decode
    // never sees stale array contents.
    always_comb begin
        slot0.valid = (count_q != '0);
        slot1.valid = (count_q >= (PTR_W+1)'(2));
        slot0.pc    = slot0.valid ? rdata0.pc  : 64'd0;
        slot0.raw   = slot0.valid ? rdata0.raw : 32'd0;
        slot1.pc    = slot1.valid ? rdata1.pc  : 64'd0;
        slot1.raw   = slot1.valid ? rdata1.raw : 32'd0;
    end

    assign out_valid0 = slot0.valid;
    assign out_valid1 = slot1.valid;
    assign out_pc0    = slot0.pc;
    assign out_pc1    = slot1.pc;
    assign out_raw0   = slot0.raw;
    assign out_raw1   = slot1.raw;
    assign count      = count_q;

endmodule

// File: tb/tb_issue_buffer.sv
// -----------------------------------------------------------------------------
// tb_issue_buffer
// Scoreboard bench for issue_buffer. The reference model is a plain queue of
// accepted entries; a negedge monitor compares every DUT output against it.
// -----------------------------------------------------------------------------
module tb_issue_buffer;
    import issue_buffer_pkg::*;

    localparam int DEPTH = 8;
    localparam int PTR_W = $clog2(DEPTH);

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             flush = 1'b0;
    logic             in_valid0 = 1'b0;
    logic             in_valid1 = 1'b0;
    logic [63:0]      in_pc0 = 64'd0;
    logic [63:0]      in_pc1 = 64'd0;
    logic [31:0]      in_raw0 = 32'd0;
    logic [31:0]      in_raw1 = 32'd0;
    logic [1:0]       pop = 2'd0;
    logic             in_ready;
    logic             out_valid0;
    logic             out_valid1;
    logic [63:0]      out_pc0;
    logic [63:0]      out_pc1;
    logic [31:0]      out_raw0;
    logic [31:0]      out_raw1;
    logic [PTR_W:0]   count;

    fetch_entry_t expQ[$];
    int total = 0;
    int passed = 0;
    bit monEn = 1'b0;

    issue_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_valid0  (in_valid0),
        .in_valid1  (in_valid1),
        .in_pc0     (in_pc0),
        .in_pc1     (in_pc1),
        .in_raw0    (in_raw0),
        .in_raw1    (in_raw1),
        .in_ready   (in_ready),
        .out_valid0 (out_valid0),
        .out_valid1 (out_valid1),
        .out_pc0    (out_pc0),
        .out_pc1    (out_pc1),
        .out_raw0   (out_raw0),
        .out_raw1   (out_raw1),
        .pop        (pop),
        .count      (count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the buffer is just an ordered list of accepted
    // instructions. Readiness is judged on the occupancy before this edge,
    // pops are limited to what is held, flush and reset empty the list.
    always @(posedge clk or negedge reset) begin
        int n;
        int np;
        fetch_entry_t e;
        if (!reset) begin
            expQ.delete();
        end else if (flush) begin
            expQ.delete();
        end else begin
            n  = expQ.size();
            np = (pop == 2'd3) ? 2 : int'(pop);
            if (np > n) np = n;
            repeat (np) void'(expQ.pop_front());
            if ((DEPTH - n) >= 2 && in_valid0) begin
                e.pc  = in_pc0;
                e.raw = in_raw0;
                expQ.push_back(e);
                if (in_valid1) begin
                    e.pc  = in_pc1;
                    e.raw = in_raw1;
                    expQ.push_back(e);
                end
            end
        end
    end

    // Monitor: every falling edge, the presented slots must be the two
    // oldest model entries (or zero when absent) and status must match.
    always @(negedge clk) begin
        int n;
        fetch_entry_t e0;
        fetch_entry_t e1;
        if (monEn) begin
            n  = expQ.size();
            e0 = '0;
            e1 = '0;
            if (n >= 1) e0 = expQ[0];
            if (n >= 2) e1 = expQ[1];
            checkOutput("mon count",    64'(count),      64'(n));
            checkOutput("mon valid0",   64'(out_valid0), 64'(n >= 1));
            checkOutput("mon valid1",   64'(out_valid1), 64'(n >= 2));
            checkOutput("mon in_ready", 64'(in_ready),   64'((DEPTH - n) >= 2));
            checkOutput("mon pc0",      out_pc0,         e0.pc);
            checkOutput("mon raw0",     64'(out_raw0),   64'(e0.raw));
            checkOutput("mon pc1",      out_pc1,         e1.pc);
            checkOutput("mon raw1",     64'(out_raw1),   64'(e1.raw));
        end
    end

    // Drive one cycle's worth of inputs just after a falling edge.
    task automatic applyStimulus(input bit v0, input bit v1,
                                 input logic [63:0] p0, input logic [31:0] r0,
                                 input logic [63:0] p1, input logic [31:0] r1,
                                 input logic [1:0] pp, input bit fl);
        @(negedge clk);
        in_valid0 = v0;
        in_valid1 = v1;
        in_pc0    = p0;
        in_raw0   = r0;
        in_pc1    = p1;
        in_raw1   = r1;
        pop       = pp;
        flush     = fl;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 64'd0, 32'd0, 64'd0, 32'd0, 2'd0, 1'b0);
    endtask

    task automatic popOnly(input logic [1:0] pp);
        applyStimulus(1'b0, 1'b0, 64'd0, 32'd0, 64'd0, 32'd0, pp, 1'b0);
    endtask

    task automatic push2(input logic [63:0] p0, input logic [63:0] p1, input logic [1:0] pp);
        applyStimulus(1'b1, 1'b1, p0, p0[31:0] ^ 32'h13, p1, p1[31:0] ^ 32'h13, pp, 1'b0);
    endtask

    task automatic push1(input logic [63:0] p0);
        applyStimulus(1'b1, 1'b0, p0, p0[31:0] ^ 32'h13, 64'd0, 32'd0, 2'd0, 1'b0);
    endtask

    initial begin
        logic [63:0] seqPc;
        logic [1:0]  rp;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        monEn = 1'b1;
        checkOutput("reset count",    64'(count),      64'd0);
        checkOutput("reset valid0",   64'(out_valid0), 64'd0);
        checkOutput("reset in_ready", 64'(in_ready),   64'd1);

        // Dual push, dual pop
        applyStimulus(1'b1, 1'b1, 64'h8000_0000, 32'h0000_0013,
                      64'h8000_0004, 32'h0010_0093, 2'd0, 1'b0);
        idle();
        checkOutput("dual count", 64'(count),    64'd2);
        checkOutput("dual pc0",   out_pc0,       64'h8000_0000);
        checkOutput("dual pc1",   out_pc1,       64'h8000_0004);
        checkOutput("dual raw1",  64'(out_raw1), 64'h0010_0093);
        popOnly(2'd2);
        idle();
        checkOutput("dual pop count", 64'(count), 64'd0);

        // Slot-1 stall: retire only one of three
        push2(64'h0, 64'h4, 2'd0);
        push1(64'h8);
        popOnly(2'd1);
        idle();
        checkOutput("stall pc0",   out_pc0,     64'h4);
        checkOutput("stall pc1",   out_pc1,     64'h8);
        checkOutput("stall count", 64'(count),  64'd2);
        popOnly(2'd3);
        idle();
        checkOutput("pop3 count", 64'(count), 64'd0);

        // Wrap-around: steady push 2 / pop 2 crosses index 7->0
        push2(64'h1000, 64'h1004, 2'd0);
        for (int i = 0; i < 6; i++) begin
            push2(64'h1008 + 64'(8 * i), 64'h100C + 64'(8 * i), 2'd2);
            checkOutput("wrap pc0", out_pc0, 64'h1000 + 64'(8 * i));
            checkOutput("wrap pc1", out_pc1, 64'h1004 + 64'(8 * i));
        end
        idle();
        checkOutput("wrap last pc0", out_pc0, 64'h1030);
        popOnly(2'd2);
        idle();
        checkOutput("wrap drain count", 64'(count), 64'd0);

        // Full with simultaneous push and pop, then over-pop
        push2(64'h2000, 64'h2004, 2'd0);
        push2(64'h2008, 64'h200C, 2'd0);
        push2(64'h2010, 64'h2014, 2'd0);
        push1(64'h2018);
        idle();
        checkOutput("full count",    64'(count),    64'd7);
        checkOutput("full in_ready", 64'(in_ready), 64'd0);
        push2(64'h9000, 64'h9004, 2'd1);
        idle();
        checkOutput("full drop count", 64'(count), 64'd6);
        checkOutput("full drop pc0",   out_pc0,    64'h2004);
        popOnly(2'd2);
        popOnly(2'd2);
        popOnly(2'd1);
        idle();
        checkOutput("overpop pre count", 64'(count), 64'd1);
        popOnly(2'd2);
        idle();
        checkOutput("overpop count",  64'(count),      64'd0);
        checkOutput("overpop valid0", 64'(out_valid0), 64'd0);

        // Flush with concurrent push and pop at count 5
        push2(64'h3000, 64'h3004, 2'd0);
        push2(64'h3008, 64'h300C, 2'd0);
        push1(64'h3010);
        applyStimulus(1'b1, 1'b1, 64'hDEAD_0000, 32'h1, 64'hDEAD_0004, 32'h2, 2'd2, 1'b1);
        #1;
        checkOutput("flush cycle valid0", 64'(out_valid0), 64'd1);
        checkOutput("flush cycle pc0",    out_pc0,         64'h3000);
        idle();
        checkOutput("flush count",  64'(count),      64'd0);
        checkOutput("flush valid0", 64'(out_valid0), 64'd0);
        push1(64'h4000);
        idle();
        checkOutput("post flush pc0", out_pc0, 64'h4000);
        popOnly(2'd1);

        // Asynchronous reset between clock edges
        push2(64'h5000, 64'h5004, 2'd0);
        push1(64'h5008);
        idle();
        checkOutput("pre reset count", 64'(count), 64'd3);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("async reset count",    64'(count),      64'd0);
        checkOutput("async reset valid0",   64'(out_valid0), 64'd0);
        checkOutput("async reset valid1",   64'(out_valid1), 64'd0);
        checkOutput("async reset in_ready", 64'(in_ready),   64'd1);
        @(negedge clk);
        reset = 1'b1;

        // Randomized traffic: a fill-biased phase, then a drain-biased one
        seqPc = 64'h1_0000_0000;
        for (int i = 0; i < 400; i++) begin
            rp = (i < 200) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(0, 3));
            applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                          seqPc, $urandom, seqPc + 64'd4, $urandom,
                          rp, $urandom_range(0, 39) == 0);
            seqPc = seqPc + 64'd8;
        end
        idle();
        repeat (2) @(negedge clk);
        monEn = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/issue_buffer.md
Name: issue_buffer

Overview:
Dual-issue instruction queue between fetch and decode. It accepts up to two fetched instructions per cycle and presents the two oldest as issue slots 0 and 1 to the decode/hazard stage. That stage retires 0, 1 or 2 slots per cycle according to its stall decision. The queue decouples fetch bursts from decode stalls and discards its contents on redirect.

Parameters:
DEPTH, 8, number of entries; power of two, >= 4.
PTR_W, $clog2(DEPTH), pointer width.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-low; buffer cleared while reset==0.
flush  in  1  redirect; discard all entries.
in_valid0  in  1  fetch slot 0 valid.
in_valid1  in  1  fetch slot 1 valid; ignored unless in_valid0.
in_pc0, in_pc1  in  64  PCs of fetch slots.
in_raw0, in_raw1  in  32  instruction words.
in_ready  out  1  free entries >= 2.
out_valid0  out  1  occupancy >= 1.
out_valid1  out  1  occupancy >= 2.
out_pc0, out_pc1  out  64  PCs of the oldest and second-oldest entries.
out_raw0, out_raw1  out  32  instruction words of the same entries.
pop  in  2  entries consumed this cycle (0, 1 or 2); 3 treated as 2.
count  out  PTR_W+1  current occupancy.

Behaviour:
- Storage: circular array of DEPTH entries {pc, raw}.
- Pointers: head and tail are PTR_W bits and wrap modulo DEPTH.
- count register: PTR_W+1 bits, range 0..DEPTH.
- Reset (reset==0, asynchronous): head=0, tail=0, count=0. Hence out_valid0/1=0 and in_ready=1. Array contents need no reset.
- Outputs are combinational from head and count; zero cycles from registered state.
  - out_pc0/out_raw0 = entry[head]; out_pc1/out_raw1 = entry[head+1 mod DEPTH].
  - Each data output is forced to 0 when its valid is 0.
- in_ready = (DEPTH - count >= 2), computed from current count only. Same-cycle pops are not credited. No combinational path from pop to in_ready.
- Push count: npush = in_ready & in_valid0 ? (1 + in_valid1) : 0.
  - Slot 0 is written at tail; slot 1 at tail+1 mod DEPTH.
  - tail += npush.
- Pop count: npop = min(pop clamped to 2, count). Over-pop never underflows.
  - head += npop.
- Simultaneous push and pop: count_next = count + npush - npop.
  - Write and read addresses never collide, because in_ready guarantees 2 free slots.
- Flush (registered, priority over all else): head=tail=count=0 next cycle.
  - A push in the same cycle is dropped; a pop is ignored.
  - Outputs remain valid during the flush cycle itself and are invalid from the next cycle.
- in_valid1 without in_valid0: nothing pushed.
- Ordering invariant: slot 0 is always older than slot 1. Program order is preserved across wrap-around.
- Full (count==DEPTH or DEPTH-1): in_ready=0, pushes dropped, state otherwise unchanged.
- Empty (count==0): out_valid0/1=0; pop has no effect.

Decomposition:
- pipes package: fetch_entry_t {u64 pc; u32 raw}; issue_slot_t {u1 valid; u64 pc; u32 raw}.
- common package: u1/u32/u64 and related typedefs.
- One natural sub-module: issue_buffer_ram, a DEPTH x fetch_entry_t array with 2 write ports and 2 asynchronous read ports. The top level holds pointers, count and control.

Test Plan:
- Reset mid-operation: fill 3 entries, pull reset=0 between clock edges -> count=0, out_valid0/1=0 and in_ready=1 immediately (asynchronous).
- Dual push, dual pop:
  - Push {0x80000000, 0x00000013}, {0x80000004, 0x00100093} -> next cycle count=2, out_pc0=0x80000000, out_pc1=0x80000004.
  - pop=2 -> count=0.
- Slot-1 stall: 3 entries (pc 0x0, 0x4, 0x8), pop=1 -> out_pc0=0x4, out_pc1=0x8, count=2.
- Wrap-around, DEPTH=8: repeatedly push 2 and pop 2 for 6 cycles -> PCs emerge strictly increasing across the index 7->0 boundary.
- Full, simultaneous, over-pop:
  - count=7: in_ready=0; push with pop=1 -> push dropped, count=6.
  - pop=2 with count=1 -> count=0.
- Flush with concurrent push and pop=2 at count=5 -> next cycle count=0, out_valid0=0; the pushed PCs never appear.
